// File: rtl/elastic_buffer_pkg.sv
// elastic_buffer_pkg: shared constants, width helpers and pointer type
// for the elastic_buffer FIFO.
package elastic_buffer_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 4;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef logic [addr_w(DEFAULT_DEPTH)-1:0] ptr_t;

endpackage

// File: rtl/elastic_buffer_mem.sv
// elastic_buffer_mem: register array, one synchronous write port and one
// asynchronous read port; contents are never reset.
module elastic_buffer_mem
  import elastic_buffer_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/elastic_buffer.sv
// elastic_buffer: DEPTH-entry registered FIFO with valid/ready handshakes.
// Define ELASTIC_BUFFER_HWM_EN to add the hwm (high-water mark) output.
module elastic_buffer
  import elastic_buffer_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int DEPTH  = DEFAULT_DEPTH,
  localparam int CNT_W  = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count,
`ifdef ELASTIC_BUFFER_HWM_EN
  output logic [CNT_W-1:0]  hwm,
`endif
  output logic              full,
  output logic              empty
);

  localparam int ADDR_W = addr_w(DEPTH);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] w_rdata;
  logic              w_push;
  logic              w_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  // in_ready depends only on state and rst, never on out_ready
  assign in_ready  = !full && !rst;
  assign out_valid = !empty;
  assign out_data  = out_valid ? w_rdata : '0;
  assign count     = r_count;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  elastic_buffer_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (in_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef ELASTIC_BUFFER_HWM_EN
  logic [CNT_W-1:0] r_hwm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hwm <= '0;
    end else if (r_count > r_hwm) begin
      r_hwm <= r_count;
    end
  end

  assign hwm = r_hwm;
`endif

endmodule

// File: tb/tb_elastic_buffer.sv
// tb_elastic_buffer: directed and random checks of elastic_buffer
// against a queue-based FIFO reference model.
module tb_elastic_buffer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;
  logic       full;
  logic       empty;
`ifdef ELASTIC_BUFFER_HWM_EN
  logic [2:0] hwm;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q[$];
  int         m_hwm = 0;

  elastic_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
`ifdef ELASTIC_BUFFER_HWM_EN
    .hwm       (hwm),
`endif
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  // Reference: a transfer happens only if the handshake holds;
  // rst wipes the queue. Inputs are stable around the edge.
  task automatic tick();
    int  c;
    bit  p;
    bit  o;
    c = q.size();
    p = in_valid && !rst && (c < DEPTH);
    o = out_ready && !rst && (c > 0);
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_hwm = 0;
    end else begin
      if (c > m_hwm) m_hwm = c;
      if (o) void'(q.pop_front());
      if (p) q.push_back(in_data);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'($urandom);
    out_ready = 1'b1;
    tick();
    tick();
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_tests++;
    if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d/%b/%b expected 0/1/0",
               count, empty, full);
    end
    n_tests++;
    if (out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_out_data: got %h expected 00", out_data);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: in_ready got %b expected 1", in_ready);
    end
  endtask

  task automatic test_single();
    in_data = 8'hA5;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_out: got %b/%h expected 1/a5",
               out_valid, out_data);
    end
    tick();
    n_tests++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL single_empty: got %b expected 1", empty);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_fill();
    int acc;
    acc = 0;
    out_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      in_data = 8'(v);
      in_valid = 1'b1;
      if (in_ready) acc++;
      tick();
    end
    n_tests++;
    if (acc != 4) begin
      n_fail++;
      $display("FAIL fill_accepted: got %0d expected 4", acc);
    end
    n_tests++;
    if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin
      n_fail++;
      $display("FAIL fill_full: got %b/%b/%0d expected 1/0/4",
               full, in_ready, count);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1 || count !== 3'd3) begin
      n_fail++;
      $display("FAIL fill_reopen: got %b/%0d expected 1/3",
               in_ready, count);
    end
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int v = 2; v <= 5; v++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 8'(v)) begin
        n_fail++;
        $display("FAIL fill_order: got %b/%h expected 1/%h",
                 out_valid, out_data, 8'(v));
      end
      tick();
    end
    n_tests++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_drain: empty got %b expected 1", empty);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_simul();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h10;
    tick();
    in_data = 8'h11;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'(8'h12 + i);
      n_tests++;
      if (out_data !== 8'(8'h10 + i)) begin
        n_fail++;
        $display("FAIL simul_data: got %h expected %h",
                 out_data, 8'(8'h10 + i));
      end
      tick();
      n_tests++;
      if (count !== 3'd2) begin
        n_fail++;
        $display("FAIL simul_count: got %0d expected 2", count);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (out_data !== 8'(8'h1A + i)) begin
        n_fail++;
        $display("FAIL simul_tail: got %h expected %h",
                 out_data, 8'(8'h1A + i));
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(8'hE0 + i);
      tick();
    end
    n_tests++;
    if (count !== 3'd3) begin
      n_fail++;
      $display("FAIL midrst_pre: count got %0d expected 3", count);
    end
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_tests++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_clear: got %0d/%b expected 0/0",
               count, out_valid);
    end
    in_valid = 1'b1;
    in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (out_data !== 8'h3C || count !== 3'd1) begin
      n_fail++;
      $display("FAIL midrst_first: got %h/%0d expected 3c/1",
               out_data, count);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] exp_d;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      in_valid = $urandom_range(0, 3) != 0;
      in_data = 8'($urandom);
      out_ready = $urandom_range(0, 2) != 0;
      if (i % 100 < 30) out_ready = $urandom_range(0, 4) == 0;
      #1;
      exp_d = (q.size() > 0) ? q[0] : 8'h00;
      n_tests++;
      if (out_valid !== (q.size() > 0) || out_data !== exp_d) begin
        n_fail++;
        $display("FAIL rand_head: got %b/%h expected %b/%h",
                 out_valid, out_data, q.size() > 0, exp_d);
      end
      n_tests++;
      if (count !== 3'(q.size()) || full !== (q.size() == DEPTH)
          || empty !== (q.size() == 0)) begin
        n_fail++;
        $display("FAIL rand_count: got %0d/%b/%b expected %0d",
                 count, full, empty, q.size());
      end
      n_tests++;
      if (in_ready !== (!rst && q.size() < DEPTH)) begin
        n_fail++;
        $display("FAIL rand_in_ready: got %b size %0d rst %b",
                 in_ready, q.size(), rst);
      end
`ifdef ELASTIC_BUFFER_HWM_EN
      n_tests++;
      if (hwm !== 3'(m_hwm)) begin
        n_fail++;
        $display("FAIL rand_hwm: got %0d expected %0d", hwm, m_hwm);
      end
`endif
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick();
    out_ready = 1'b0;
  endtask

`ifdef ELASTIC_BUFFER_HWM_EN
  task automatic test_hwm();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    out_ready = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (hwm !== 3'd3) begin
        n_fail++;
        $display("FAIL hwm_tail: got %0d expected 3", hwm);
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (hwm !== 3'd0) begin
      n_fail++;
      $display("FAIL hwm_reset: got %0d expected 0", hwm);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_simul();
    test_mid_reset();
    test_random();
`ifdef ELASTIC_BUFFER_HWM_EN
    test_hwm();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
